// File: rtl/frame_rle_decoder_if.sv
// Token-in / pixel-out bus of the RLE frame decoder.
// The slave modport is the decoder side; the master modport is the side that feeds tokens and consumes pixels.
interface frame_rle_decoder_if #(
    parameter int IDX_W = 4
);
    logic             i_frame_start;
    logic [7:0]       i_data;
    logic             i_valid;
    logic             o_ready;
    logic [IDX_W-1:0] o_idx;
    logic             o_valid;
    logic             i_ready;
    logic [9:0]       o_x;
    logic [8:0]       o_y;
    logic             o_eol;
    logic             o_eof;
    logic             o_err;

    modport slave (
        input  i_frame_start, i_data, i_valid, i_ready,
        output o_ready, o_idx, o_valid, o_x, o_y, o_eol, o_eof, o_err
    );

    modport master (
        output i_frame_start, i_data, i_valid, i_ready,
        input  o_ready, o_idx, o_valid, o_x, o_y, o_eol, o_eof, o_err
    );
endinterface

// File: rtl/frame_rle_decoder.sv
// Expands {idx, run} tokens into raster-ordered palette indices with x/y tracking and eol/eof flags.
// Optional FRAME_RLE_EXT_RUN_EN: run field 4'hF is followed by an extension byte giving 16+e pixels.
module frame_rle_decoder #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int IDX_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    frame_rle_decoder_if.slave  bus
);
    localparam logic [9:0] X_LAST = 10'(FRAME_W - 1);
    localparam logic [8:0] Y_LAST = 9'(FRAME_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT
`ifdef FRAME_RLE_EXT_RUN_EN
        , S_EXT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [8:0]       run_q, run_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             err_q, err_d;

    logic valid, eol, eof, ready, tok, pix, load;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;

        valid = (state_q == S_EMIT);
        eol   = valid && (x_q == X_LAST);
        eof   = eol && (y_q == Y_LAST);

        // The reload window opens only on the last pixel of a run, and never on the frame's last pixel.
        case (state_q)
            S_FETCH: ready = 1'b1;
`ifdef FRAME_RLE_EXT_RUN_EN
            S_EXT:   ready = 1'b1;
`endif
            S_EMIT:  ready = (run_q == 9'd1) && bus.i_ready && !eof;
            default: ready = 1'b0;
        endcase
        if (bus.i_frame_start) ready = 1'b0;

        tok  = bus.i_valid && ready;
        pix  = valid && bus.i_ready;
        load = tok && ((state_q == S_FETCH) || (state_q == S_EMIT));

        if (bus.i_frame_start) begin
            state_d = S_FETCH;
            run_d   = 9'd0;
            x_d     = 10'd0;
            y_d     = 9'd0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
`ifdef FRAME_RLE_EXT_RUN_EN
                S_EXT: begin
                    if (tok) begin
                        run_d   = 9'd16 + {1'b0, bus.i_data};
                        state_d = S_EMIT;
                    end
                end
`endif
                S_EMIT: begin
                    if (pix) begin
                        if (x_q == X_LAST) begin
                            x_d = 10'd0;
                            y_d = y_q + 9'd1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                        if (eof) begin
                            state_d = S_IDLE;
                            run_d   = 9'd0;
                            x_d     = 10'd0;
                            y_d     = 9'd0;
                            if (run_q > 9'd1) err_d = 1'b1;
                        end else if (run_q == 9'd1) begin
                            state_d = S_FETCH;
                            run_d   = 9'd0;
                        end else begin
                            run_d = run_q - 9'd1;
                        end
                    end
                end
                default: ;
            endcase

            // A newly accepted token overrides the FETCH/EMIT bookkeeping above.
            if (load) begin
                idx_d = IDX_W'(bus.i_data[7:4]);
`ifdef FRAME_RLE_EXT_RUN_EN
                if (bus.i_data[3:0] == 4'hF) begin
                    state_d = S_EXT;
                    run_d   = 9'd0;
                end else begin
                    state_d = S_EMIT;
                    run_d   = {5'd0, bus.i_data[3:0]} + 9'd1;
                end
`else
                state_d = S_EMIT;
                run_d   = {5'd0, bus.i_data[3:0]} + 9'd1;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            run_q   <= 9'd0;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid;
    assign bus.o_idx   = idx_q;
    assign bus.o_x     = x_q;
    assign bus.o_y     = y_q;
    assign bus.o_eol   = eol;
    assign bus.o_eof   = eof;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_frame_rle_decoder.sv
// Directed bench for frame_rle_decoder: a 640x480 instance and a 4x2 instance share one stimulus stream.
module tb_frame_rle_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    frame_rle_decoder_if #(.IDX_W(4)) m_if ();
    frame_rle_decoder_if #(.IDX_W(4)) s_if ();

    frame_rle_decoder #(.FRAME_W(640), .FRAME_H(480), .IDX_W(4)) u_main (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (m_if)
    );

    frame_rle_decoder #(.FRAME_W(4), .FRAME_H(2), .IDX_W(4)) u_small (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (s_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input logic fs, input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        m_if.i_frame_start = fs; m_if.i_valid = v; m_if.i_data = d; m_if.i_ready = r;
        s_if.i_frame_start = fs; s_if.i_valid = v; s_if.i_data = d; s_if.i_ready = r;
        #1;
    endtask

    initial begin
        m_if.i_frame_start = 1'b0; m_if.i_valid = 1'b0; m_if.i_data = 8'h00; m_if.i_ready = 1'b0;
        s_if.i_frame_start = 1'b0; s_if.i_valid = 1'b0; s_if.i_data = 8'h00; s_if.i_ready = 1'b0;

        // Reset state
        drive(0, 0, 8'h00, 0);
        chk("rst_ready", 32'(m_if.o_ready), 0);
        chk("rst_valid", 32'(m_if.o_valid), 0);
        chk("rst_idx",   32'(m_if.o_idx),   0);
        chk("rst_x",     32'(m_if.o_x),     0);
        chk("rst_y",     32'(m_if.o_y),     0);
        chk("rst_eol",   32'(m_if.o_eol),   0);
        chk("rst_eof",   32'(m_if.o_eof),   0);
        chk("rst_err",   32'(m_if.o_err),   0);
        rst = 1'b0;

        // Single run of 3 pixels of index 3
        drive(1, 1, 8'h32, 1);
        chk("fs_ready", 32'(m_if.o_ready), 0);
        drive(0, 1, 8'h32, 1);
        chk("fetch_ready", 32'(m_if.o_ready), 1);
        chk("fetch_valid", 32'(m_if.o_valid), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 1);
            chk("r32_valid", 32'(m_if.o_valid), 1);
            chk("r32_idx",   32'(m_if.o_idx),   3);
            chk("r32_x",     32'(m_if.o_x),     32'(i));
            chk("r32_ready", 32'(m_if.o_ready), (i == 2) ? 1 : 0);
            chk("r32_eol",   32'(m_if.o_eol),   0);
        end
        drive(0, 0, 8'h00, 1);
        chk("r32_done_valid", 32'(m_if.o_valid), 0);
        chk("r32_done_x",     32'(m_if.o_x),     3);

        // Asynchronous reset while emitting
        drive(0, 1, 8'h11, 1);
        drive(0, 0, 8'h00, 0);
        chk("mid_valid", 32'(m_if.o_valid), 1);
        chk("mid_idx",   32'(m_if.o_idx),   1);
        chk("mid_x",     32'(m_if.o_x),     3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(m_if.o_valid), 0);
        chk("arst_idx",   32'(m_if.o_idx),   0);
        chk("arst_x",     32'(m_if.o_x),     0);
        chk("arst_ready", 32'(m_if.o_ready), 0);
        rst = 1'b0;
        drive(0, 1, 8'h45, 1);
        chk("idle_ready", 32'(m_if.o_ready), 0);
        drive(0, 1, 8'h45, 1);
        chk("idle_valid", 32'(m_if.o_valid), 0);
        chk("idle_ready2", 32'(m_if.o_ready), 0);

        // Back-to-back single-pixel tokens
        drive(1, 0, 8'h00, 1);
        drive(0, 1, 8'h10, 1);
        drive(0, 1, 8'h20, 1);
        chk("b2b_ready", 32'(m_if.o_ready), 1);
        chk("b2b_idx0",  32'(m_if.o_idx),   1);
        chk("b2b_x0",    32'(m_if.o_x),     0);
        drive(0, 0, 8'h00, 1);
        chk("b2b_valid1", 32'(m_if.o_valid), 1);
        chk("b2b_idx1",   32'(m_if.o_idx),   2);
        chk("b2b_x1",     32'(m_if.o_x),     1);
        drive(0, 0, 8'h00, 1);
        chk("b2b_end_valid", 32'(m_if.o_valid), 0);

        // Backpressure on a 2-pixel run
        drive(1, 0, 8'h00, 1);
        drive(0, 1, 8'h51, 1);
        drive(0, 0, 8'h00, 1);
        chk("bp_idx", 32'(m_if.o_idx), 5);
        chk("bp_x0",  32'(m_if.o_x),   0);
        drive(0, 0, 8'h00, 0);
        chk("bp_hold1_x",     32'(m_if.o_x),     1);
        chk("bp_hold1_valid", 32'(m_if.o_valid), 1);
        chk("bp_hold1_ready", 32'(m_if.o_ready), 0);
        drive(0, 0, 8'h00, 0);
        chk("bp_hold2_x",   32'(m_if.o_x),   1);
        chk("bp_hold2_idx", 32'(m_if.o_idx), 5);
        drive(0, 0, 8'h00, 1);
        chk("bp_last_ready", 32'(m_if.o_ready), 1);
        drive(0, 0, 8'h00, 1);
        chk("bp_done_valid", 32'(m_if.o_valid), 0);
        chk("bp_done_x",     32'(m_if.o_x),     2);

        // Run field 4'hF followed by byte 8'h04
        drive(1, 0, 8'h00, 1);
        drive(0, 1, 8'h7F, 1);
`ifdef FRAME_RLE_EXT_RUN_EN
        drive(0, 1, 8'h04, 1);
        chk("ext_valid", 32'(m_if.o_valid), 0);
        chk("ext_ready", 32'(m_if.o_ready), 1);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 8'h00, 1);
            chk("ext_pix_idx", 32'(m_if.o_idx),   7);
            chk("ext_pix_x",   32'(m_if.o_x),     32'(i));
            chk("ext_pix_vld", 32'(m_if.o_valid), 1);
        end
        drive(0, 0, 8'h00, 1);
        chk("ext_end_valid", 32'(m_if.o_valid), 0);
        chk("ext_end_x",     32'(m_if.o_x),     20);
`else
        for (int i = 0; i < 16; i++) begin
            drive(0, (i == 15), 8'h04, 1);
            chk("f16_idx", 32'(m_if.o_idx),   7);
            chk("f16_x",   32'(m_if.o_x),     32'(i));
            chk("f16_vld", 32'(m_if.o_valid), 1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 8'h00, 1);
            chk("z5_idx", 32'(m_if.o_idx),   0);
            chk("z5_x",   32'(m_if.o_x),     32'(16 + i));
            chk("z5_vld", 32'(m_if.o_valid), 1);
        end
        drive(0, 0, 8'h00, 1);
        chk("z5_end_valid", 32'(m_if.o_valid), 0);
        chk("z5_end_x",     32'(m_if.o_x),     21);
`endif

        // End of frame on the 4x2 instance, with the last run overrunning it
        drive(1, 0, 8'h00, 1);
        drive(0, 1, 8'hA3, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, (i == 3), 8'hB4, 1);
            chk("eol_a_idx", 32'(s_if.o_idx), 32'hA);
            chk("eol_a_x",   32'(s_if.o_x),   32'(i));
            chk("eol_a_y",   32'(s_if.o_y),   0);
            chk("eol_a_eol", 32'(s_if.o_eol), (i == 3) ? 1 : 0);
            chk("eol_a_eof", 32'(s_if.o_eof), 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'h21, 1);
            chk("eof_b_idx",   32'(s_if.o_idx),   32'hB);
            chk("eof_b_x",     32'(s_if.o_x),     32'(i));
            chk("eof_b_y",     32'(s_if.o_y),     1);
            chk("eof_b_eof",   32'(s_if.o_eof),   (i == 3) ? 1 : 0);
            chk("eof_b_ready", 32'(s_if.o_ready), 0);
            chk("eof_b_err",   32'(s_if.o_err),   0);
        end
        drive(0, 1, 8'h21, 1);
        chk("post_eof_valid", 32'(s_if.o_valid), 0);
        chk("post_eof_err",   32'(s_if.o_err),   1);
        chk("post_eof_ready", 32'(s_if.o_ready), 0);
        drive(0, 1, 8'h21, 1);
        chk("post_eof_valid2", 32'(s_if.o_valid), 0);
        chk("post_eof_err2",   32'(s_if.o_err),   1);
        drive(1, 1, 8'h21, 1);
        chk("restart_ready", 32'(s_if.o_ready), 0);
        chk("restart_err_held", 32'(s_if.o_err), 1);
        drive(0, 0, 8'h00, 1);
        chk("restart_err", 32'(s_if.o_err),   0);
        chk("restart_rdy", 32'(s_if.o_ready), 1);
        chk("restart_x",   32'(s_if.o_x),     0);
        chk("restart_y",   32'(s_if.o_y),     0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_rle_decoder.md
Name: frame_rle_decoder

Overview:
- Expands a run-length-encoded byte stream from frame storage into one 4-bit palette index per pixel, in raster order, for one frame.
- Sits directly upstream of the 16-entry palette lookup. Its o_idx drives the palette index, and the 24-bit colour goes to the VGA output stage.
- Tracks pixel x/y position and flags end-of-line and end-of-frame for the display timing logic.

Parameters:
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame.
- IDX_W, 4, palette index width. Must match the 16-entry palette.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_frame_start  in  1  one-cycle pulse: abort any frame in progress, restart at (0,0), clear o_err
- i_data  in  8  token {idx[7:4], run[3:0]}
- i_valid  in  1  i_data valid
- o_ready  out  1  decoder accepts i_data this cycle
- o_idx  out  IDX_W  current pixel palette index
- o_valid  out  1  o_idx/o_x/o_y valid
- i_ready  in  1  downstream consumes the pixel this cycle
- o_x  out  10  pixel column, 0..FRAME_W-1
- o_y  out  9  pixel row, 0..FRAME_H-1
- o_eol  out  1  current pixel is last in its line
- o_eof  out  1  current pixel is last in the frame
- o_err  out  1  sticky overrun flag

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs 0: o_ready, o_valid, o_idx, o_x, o_y, o_eol, o_eof, o_err. Run counter = 0.
- Run length: run field r encodes r+1 pixels (1..16). Run counter is 9 bits.
- Token transfer: occurs when i_valid && o_ready. Pixel transfer: occurs when o_valid && i_ready.
- IDLE:
  - o_ready=0, o_valid=0.
  - i_frame_start moves to FETCH with x=y=0.
- FETCH:
  - o_ready=1, o_valid=0.
  - On token transfer: latch idx, set run_left=r+1, go to EMIT.
  - First pixel appears with o_valid=1 on the next cycle (latency 1).
- EMIT:
  - o_valid=1. o_idx, o_x, o_y are registered and held stable while i_ready=0.
  - On each pixel transfer: run_left decrements. x increments; on x=FRAME_W-1, x wraps to 0 and y increments.
- Full throughput: o_ready=1 in EMIT when run_left==1 && i_ready==1 (combinational).
  - A token accepted that cycle reloads the run with no bubble.
  - If no token is transferred, go to FETCH.
- Flags:
  - o_eol = (o_x==FRAME_W-1) && o_valid.
  - o_eof = o_eol && (o_y==FRAME_H-1).
- End of frame: transfer of the o_eof pixel moves to IDLE. o_ready=0 that cycle, so no token is accepted.
  - If run_left>1 at that point: remaining pixels are discarded and o_err is set.
  - o_err stays set until i_frame_start or reset.
- i_frame_start in any state takes priority over every other event that cycle:
  - o_valid=0, run_left=0, x=y=0, o_err=0; state goes to FETCH. No token is accepted that cycle.
- Index 0..15 is passed through unmodified. No palette knowledge lives in this block.

Optional Feature:
- Macro: FRAME_RLE_EXT_RUN_EN.
- Defined:
  - Run field 4'hF means an extended run; the next byte is an extension byte e.
  - Run length = 16+e (16..271). State EXT is entered from FETCH, or from the EMIT reload path.
  - EXT: o_ready=1, o_valid=0. On transfer: run_left=16+e, go to EMIT.
  - i_frame_start in EXT goes to FETCH and drops the pending token.
- Undefined:
  - Run field 4'hF means 16 pixels. The EXT state is not built.

Test Plan:
- Reset mid-EMIT (i_rst pulse while o_valid=1) -> all outputs 0 immediately; i_frame_start required before any token is accepted.
- i_frame_start, token 8'h32, i_ready=1 -> o_idx=3 for 3 cycles at x=0,1,2; first o_valid one cycle after the token transfer.
- Back-to-back tokens 8'h10 then 8'h20 with i_valid and i_ready high throughout -> o_idx sequence 1,2 on consecutive cycles, no bubble.
- Backpressure: token 8'h51, i_ready toggling 1,0,0,1 -> o_idx=5, o_x holds at 1 while i_ready=0; exactly 2 pixels emitted.
- FRAME_W=4, FRAME_H=2, tokens 8'hA3, 8'hB4 -> o_eol at (3,0); o_eof at (3,1); remaining B pixels discarded; o_err=1; o_ready=0 until the next i_frame_start.
- With FRAME_RLE_EXT_RUN_EN: tokens 8'h7F, 8'h04 -> 20 pixels with o_idx=7. Without the macro: 16 pixels, then 8'h04 is decoded as an index-0 run of 5.
